// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the front end of the pipeline.
//
//   NOP_INST      : instruction word presented to decode when nothing is valid.
//   PC_STEP       : byte distance between sequential instructions.
//   fetch_entry_t : one prefetch entry, {instruction, address of next inst}.
//                   Fields are XLEN wide; blocks with other widths build their
//                   own entry type with the same field order.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INST = 32'h0;

  localparam int unsigned PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
  } fetch_entry_t;

endpackage : pipe_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock show-ahead FIFO with a synchronous flush.
//
//   Ports
//     clk_i    : clock, all state changes on the rising edge
//     rst_i    : asynchronous active-high reset (pointers and count only)
//     flush_i  : empty the FIFO on the next edge; overrides push and pop
//     push_i   : write data_i at the tail (ignored when full unless popping)
//     pop_i    : discard the head entry (ignored when empty)
//     data_i   : write data
//     head_o   : current head entry, valid only while empty_o is low
//     count_o  : number of occupied entries, 0..DEPTH
//     empty_o  : no entries held
//     full_o   : DEPTH entries held
//
//   DEPTH must be a power of two so the pointers can wrap by overflow.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic pop_ok;
  logic push_ok;

  assign empty_o = (count == '0);
  assign full_o  = (count == CNT_W'(DEPTH));

  // A full FIFO may still accept a write when the head leaves in the same
  // cycle, so the pop qualification feeds the push qualification.
  assign pop_ok  = pop_i  & ~empty_o & ~flush_i;
  assign push_ok = push_i & ~flush_i & (~full_o | pop_ok);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // NOTE: the data array is deliberately left out of reset; its contents are
  // never observed while count is zero, and resetting it would cost a reset
  // net on every storage bit.
  always_ff @(posedge clk_i) begin
    if (push_ok) storage[wr_ptr] <= data_i;
  end

  assign head_o  = storage[rd_ptr];
  assign count_o = count;

endmodule : sync_fifo

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch stage: owns the fetch PC and a DEPTH-entry prefetch FIFO
//   of {inst, pc+4} between instruction memory and decode. Fetching continues
//   while decode stalls until the FIFO is full. A redirect flushes the FIFO
//   and reloads the PC with a word-aligned target.
//
//   Ports
//     clk_i          : clock, rising edge
//     rst_i          : asynchronous active-high reset
//     start_i        : fetch enable; when low the PC holds, the FIFO drains
//     imem_addr_o    : instruction memory address (the fetch PC)
//     imem_inst_i    : instruction memory data for imem_addr_o, same cycle
//     stall_i        : decode is not accepting the head entry
//     redirect_i     : flush and load redirect_pc_i (highest priority)
//     redirect_pc_i  : redirect target; low two bits are ignored
//     valid_o        : head entry valid
//     inst_o         : head instruction, NOP when not valid
//     pc4_o          : head entry's pc+4, zero when not valid
//     count_o        : occupied FIFO entries
// -----------------------------------------------------------------------------
module fetch_queue
  import pipe_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int             CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [INST_W-1:0] imem_inst_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc4_o,
  output logic [CNT_W-1:0]  count_o
);

  // Same field order as pipe_pkg::fetch_entry_t, sized by this instance.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc4;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] redirect_target;
  entry_t            wr_entry;
  entry_t            head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push;

  // Sequential address; wraps modulo 2^ADDR_W by plain overflow.
  assign pc_next = pc + ADDR_W'(PC_STEP);

  // Misaligned redirect targets are forced to a word boundary.
  assign redirect_target = {redirect_pc_i[ADDR_W-1:2], 2'b00};

  // Decode consumes the head whenever it is valid and not stalled. A stall
  // with nothing valid is harmless because pop is already gated by valid_o.
  assign pop  = valid_o & ~stall_i;

  // No fetch in a redirect cycle: the memory word belongs to the old path.
  assign push = start_i & ~redirect_i & (~fifo_full | pop);

  assign wr_entry = '{inst: imem_inst_i, pc4: pc_next};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc <= RESET_PC;
    end else if (redirect_i) begin
      pc <= redirect_target;
    end else if (push) begin
      pc <= pc_next;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (wr_entry),
    .head_o  (head),
    .count_o (count_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign imem_addr_o = pc;
  assign valid_o     = ~fifo_empty;

  // Stale storage must never leak to decode: zero the head when not valid.
  assign inst_o = valid_o ? head.inst : INST_W'(NOP_INST);
  assign pc4_o  = valid_o ? head.pc4  : '0;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Self-checking bench for fetch_queue (default parameters). A queue-based
//   reference model tracks the fetch PC and the prefetch contents; a compare
//   process checks every DUT output against it on each falling edge. Directed
//   sequences pin the model with hand-computed literals, then randomized
//   stimulus (including redirects and asynchronous resets) runs against it.
//   Instruction memory returns address ^ mem_xor.
// -----------------------------------------------------------------------------
module tb_fetch_queue;
  import pipe_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              start;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_inst;
  logic              stall;
  logic              redirect;
  logic [31:0]       rpc;
  logic              valid;
  logic [31:0]       inst;
  logic [31:0]       pc4;
  logic [CNT_W-1:0]  count;
  logic [31:0]       mem_xor;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  fetch_entry_t mq[$];
  logic [31:0]  mpc = 32'h0;

  fetch_queue #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .imem_addr_o   (imem_addr),
    .imem_inst_i   (imem_inst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (rpc),
    .valid_o       (valid),
    .inst_o        (inst),
    .pc4_o         (pc4),
    .count_o       (count)
  );

  assign imem_inst = imem_addr ^ mem_xor;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = 32'h0;
  endtask

  // One clock edge of the fetch stage, from the behavioural rules.
  task automatic model_step();
    int           occ;
    bit           do_pop;
    bit           do_push;
    fetch_entry_t e;
    occ     = mq.size();
    do_pop  = (occ != 0) && !stall;
    do_push = start && !redirect && ((occ < DEPTH) || do_pop);
    if (redirect) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.inst = mpc ^ mem_xor;
        e.pc4  = mpc + 32'd4;
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Compare process: outputs depend only on registered state, so the falling
  // edge is a stable sampling point.
  always @(negedge clk) begin
    logic [31:0] exp_inst;
    logic [31:0] exp_pc4;
    exp_inst = (mq.size() != 0) ? mq[0].inst : 32'h0;
    exp_pc4  = (mq.size() != 0) ? mq[0].pc4  : 32'h0;
    check("imem_addr", 64'(imem_addr), 64'(mpc));
    check("valid",     64'(valid),     64'(mq.size() != 0));
    check("inst",      64'(inst),      64'(exp_inst));
    check("pc4",       64'(pc4),       64'(exp_pc4));
    check("count",     64'(count),     64'(mq.size()));
  end

  initial begin
    int exp_cnt[6];
    exp_cnt = '{1, 2, 3, 4, 4, 4};

    rst      = 1'b1;
    start    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    rpc      = 32'h0;
    mem_xor  = 32'h0;

    @(negedge clk);
    @(negedge clk);
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_inst",  64'(inst),  64'd0);
    check("rst_pc4",   64'(pc4),   64'd0);
    check("rst_addr",  64'(imem_addr), 64'd0);
    rst   = 1'b0;
    start = 1'b1;

    // Streaming: first fetch visible one cycle later, occupancy stays 1.
    @(negedge clk);
    check("stream0_inst",  64'(inst),  64'h0);
    check("stream0_valid", 64'(valid), 64'd1);
    check("stream0_pc4",   64'(pc4),   64'h4);
    check("stream0_count", 64'(count), 64'd1);
    check("stream0_addr",  64'(imem_addr), 64'h4);
    @(negedge clk);
    check("stream1_inst",  64'(inst),  64'h4);
    check("stream1_pc4",   64'(pc4),   64'h8);
    check("stream1_count", 64'(count), 64'd1);
    check("stream1_addr",  64'(imem_addr), 64'h8);

    // Redirect to 0 to get back to an empty queue.
    redirect = 1'b1;
    rpc      = 32'h0;
    @(negedge clk);
    check("empty_count", 64'(count), 64'd0);
    check("empty_addr",  64'(imem_addr), 64'h0);
    redirect = 1'b0;
    stall    = 1'b1;

    // Stalled decode: queue fills to DEPTH then fetch stops.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("stall_count", 64'(count), 64'(exp_cnt[k]));
    end
    check("stall_addr", 64'(imem_addr), 64'h10);
    check("stall_head", 64'(inst), 64'h0);
    stall = 1'b0;

    // Release: full queue pushes and pops in the same cycle.
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("release_inst", 64'(inst), 64'(k * 4));
      if (k == 1) begin
        check("release_count", 64'(count), 64'd4);
        check("release_addr",  64'(imem_addr), 64'h14);
      end
    end

    // Fetch disabled for one cycle: PC holds, queue drains to 3.
    start = 1'b0;
    @(negedge clk);
    check("nostart_count", 64'(count), 64'd3);
    check("nostart_addr",  64'(imem_addr), 64'h20);

    // Redirect under stall with a misaligned target.
    start    = 1'b1;
    stall    = 1'b1;
    redirect = 1'b1;
    rpc      = 32'h103;
    @(negedge clk);
    check("redir_valid", 64'(valid), 64'd0);
    check("redir_count", 64'(count), 64'd0);
    check("redir_addr",  64'(imem_addr), 64'h100);
    redirect = 1'b0;
    stall    = 1'b0;
    @(negedge clk);
    check("redir_inst", 64'(inst), 64'h100);
    check("redir_pc4",  64'(pc4),  64'h104);
    stall = 1'b1;
    @(negedge clk);
    check("pre_rst_count", 64'(count), 64'd2);

    // Asynchronous reset in the middle of the low phase.
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(valid), 64'd0);
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_inst",  64'(inst),  64'd0);
    check("async_rst_pc4",   64'(pc4),   64'd0);
    check("async_rst_addr",  64'(imem_addr), 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    stall = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("restart_inst", 64'(inst), 64'h0);
    check("restart_addr", 64'(imem_addr), 64'h4);

    // PC wrap from the top of the address space.
    redirect = 1'b1;
    rpc      = 32'hFFFF_FFFE;
    @(negedge clk);
    check("wrap_addr0", 64'(imem_addr), 64'hFFFF_FFFC);
    redirect = 1'b0;
    @(negedge clk);
    check("wrap_inst", 64'(inst), 64'hFFFF_FFFC);
    check("wrap_pc4",  64'(pc4),  64'h0);
    check("wrap_addr", 64'(imem_addr), 64'h0);

    // Randomized traffic against the model.
    mem_xor = 32'h5A5A_0000;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      start    = ($urandom_range(99) < 85);
      stall    = ($urandom_range(99) < 40);
      redirect = ($urandom_range(99) < 5);
      rpc      = $urandom();
      if ($urandom_range(199) == 0) begin
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_fetch_queue

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch stage; successor to the fixed single-register PC / IF-ID path.
- Owns the fetch PC and a prefetch FIFO of DEPTH entries holding {inst, pc+4}, sitting between Instruction_Memory and the decode stage.
- Keeps fetching while decode is stalled, up to DEPTH entries.
- Supports a flushing redirect for branch, jump and exception targets.

Parameters:
- ADDR_W, 32: PC and address width.
- INST_W, 32: instruction width.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- RESET_PC, 0: fetch PC after reset.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  fetch enable; when low, no new fetch but dequeue continues.
- imem_addr_o  out  ADDR_W  address to instruction memory; equals the fetch PC.
- imem_inst_i  in  INST_W  instruction memory data, combinational, same cycle as imem_addr_o.
- stall_i  in  1  decode not accepting (hazard unit IFIDWrite inverted).
- redirect_i  in  1  flush the FIFO and load a new fetch PC.
- redirect_pc_i  in  ADDR_W  redirect target.
- valid_o  out  1  head entry valid.
- inst_o  out  INST_W  head instruction; all-zero (NOP) when valid_o=0.
- pc4_o  out  ADDR_W  head entry's pc+4; zero when valid_o=0.
- count_o  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (async, any time, including mid-operation):
  - fetch PC = RESET_PC; rd/wr pointers = 0; count = 0.
  - valid_o = 0, inst_o = 0, pc4_o = 0, count_o = 0.
- pop = valid_o & ~stall_i.
- push = start_i & ~redirect_i & (count < DEPTH | pop). A full FIFO with a same-cycle pop still pushes.
- On push:
  - storage[wr] <= {imem_inst_i, PC+4}; wr advances.
  - PC <= PC+4, modulo 2^ADDR_W, so 0xFFFFFFFC wraps to 0.
- On pop: rd advances.
- count update: count + push - pop; count never exceeds DEPTH.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Show-ahead outputs: inst_o / pc4_o / valid_o reflect storage[rd] combinationally from registered state.
- Latency: an instruction fetched in cycle N is visible at decode in cycle N+1 when the FIFO was empty.
- Redirect (highest priority, overrides stall_i, push and pop):
  - next edge: count = 0, rd = wr = 0, valid_o = 0.
  - PC <= {redirect_pc_i[ADDR_W-1:2], 2'b00}; misaligned low bits are forced to 0.
  - No push in the redirect cycle; fetching resumes from the target the following cycle.
- stall_i with valid_o=0: no effect.
- start_i low: PC holds, FIFO drains normally.
- start_i low combined with redirect_i: PC still loads the target.
- Empty plus push: entry becomes head on the next cycle; no same-cycle bypass.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP_INST = 32'h0.
  - PC_STEP = 4.
  - fetch_entry_t = struct {inst, pc4}.
- One natural sub-module: sync_fifo, parametrised by WIDTH and DEPTH, with push/pop/flush, count, and show-ahead head.
- fetch_queue adds the PC register, push/pop/redirect arbitration, and output zeroing.

Test Plan:
- Reset then start_i=1, stall_i=0, memory word = address:
  - imem_addr_o steps 0,4,8…
  - inst_o = 0 in cycle 1, then 4 in cycle 2; pc4_o = inst_o+4.
  - count_o stays at 1.
- stall_i=1 for 6 cycles from empty:
  - count_o rises 1,2,3,4, then holds 4.
  - imem_addr_o holds at 16.
  - On release, inst_o sequence is 0,4,8,12,16 with no gaps or duplicates.
- Full FIFO (count 4) with stall_i dropping: push and pop in the same cycle; count_o stays 4 and PC advances by 4.
- redirect_i=1, redirect_pc_i=0x103 while count=3 and stall_i=1:
  - next cycle valid_o=0, count_o=0, imem_addr_o=0x100.
  - following cycle inst_o = mem[0x100].
- rst_i asserted mid-cycle with count=2:
  - outputs zero immediately, without waiting for a clock edge.
  - after release, fetch restarts at RESET_PC.
- PC wrap: redirect to 0xFFFFFFFC; the next fetch address is 0x0 and pc4_o of that entry is 0x0.
